lcd_ctrl: RTL and testbench

Write-only HD44780-style character LCD driver that sits on the far side of the LSU's LCD output register word. Software writes a command/data byte plus a toggle bit into that word. The block then sequences the LCD pins with correct setup, enable-pulse, hold and execution timing. Busy and done status are fed back so software can poll them through the input-peripheral region.

---
 rtl/lcd_ctrl_if.sv | 40 ++++
 rtl/lcd_ctrl.sv | 160 ++++++++++++++++
 tb/tb_lcd_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl_if
// Purpose  : Bundles the LSU-facing LCD register word and the LCD pin / status
//            outputs of lcd_ctrl into one interface.
// Signals  : io_lcd_i    [31:0] LCD register word (driven by the master)
//            lcd_data_o  [7:0]  LCD data bus
//            lcd_rs_o           LCD register select
//            lcd_rw_o           LCD read/write (always write)
//            lcd_en_o           LCD enable strobe
//            lcd_on_o           LCD power / backlight enable
//            lcd_busy_o         transaction in progress
//            lcd_done_o         one-cycle completion pulse
// Modports : master - register-word owner (LSU side)
//            slave  - lcd_ctrl
// Revision : 1.0 - initial release
// ============================================================================
interface lcd_ctrl_if;
   logic [31:0] io_lcd_i;
   logic [7:0]  lcd_data_o;
   logic        lcd_rs_o;
   logic        lcd_rw_o;
   logic        lcd_en_o;
   logic        lcd_on_o;
   logic        lcd_busy_o;
   logic        lcd_done_o;

   modport master (
      output io_lcd_i,
      input  lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o,
      input  lcd_on_o, lcd_busy_o, lcd_done_o
   );

   modport slave (
      input  io_lcd_i,
      output lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o,
      output lcd_on_o, lcd_busy_o, lcd_done_o
   );
endinterface
`default_nettype wire

// File: rtl/lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lcd_ctrl
// Purpose  : Write-only HD44780-style character LCD driver. A toggle bit in the
//            LCD register word requests one write; the block sequences setup,
//            enable pulse, hold and execution wait, then reports completion.
// Ports    : clk_i   - system clock
//            rst_ni  - asynchronous active-low reset
//            bus     - lcd_ctrl_if.slave (register word in, LCD pins and
//                      busy/done status out)
// Revision : 1.0 - initial release
// ============================================================================
module lcd_ctrl #(
   parameter int unsigned T_SETUP     = 2,
   parameter int unsigned T_PULSE     = 12,
   parameter int unsigned T_HOLD      = 2,
   parameter int unsigned T_EXEC      = 2000,
   parameter int unsigned T_EXEC_LONG = 82000
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   lcd_ctrl_if.slave bus
);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_setup = 3'd1;
   localparam logic [2:0] c_st_pulse = 3'd2;
   localparam logic [2:0] c_st_hold  = 3'd3;
   localparam logic [2:0] c_st_wait  = 3'd4;

   localparam logic [16:0] c_ld_setup = 17'(T_SETUP);
   localparam logic [16:0] c_ld_pulse = 17'(T_PULSE);
   localparam logic [16:0] c_ld_hold  = 17'(T_HOLD);
   localparam logic [16:0] c_ld_exec  = 17'(T_EXEC);
   localparam logic [16:0] c_ld_long  = 17'(T_EXEC_LONG);
   localparam logic [16:0] c_cnt_one  = 17'd1;

   logic [2:0]  state_q, state_d;
   logic [16:0] cnt_q, cnt_d;
   logic        ack_tgl_q, ack_tgl_d;
   logic        tgl_q, tgl_d;
   logic        rs_q, rs_d;
   logic [7:0]  data_q, data_d;
   logic        en_q, en_d;
   logic        done_q, done_d;
   logic        on_q;

   logic        pending;
   logic        long_cmd;
   logic        cnt_last;
   logic        unused_bits;

   assign unused_bits = ^bus.io_lcd_i[29:9];

   // A request is outstanding whenever software's toggle differs from the
   // last acknowledged toggle.
   assign pending  = bus.io_lcd_i[30] != ack_tgl_q;

   // Clear display (0x01) and return home (0x02/0x03) need the long wait.
   assign long_cmd = !rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);

   assign cnt_last = (cnt_q == c_cnt_one);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ack_tgl_d = ack_tgl_q;
      tgl_d     = tgl_q;
      rs_d      = rs_q;
      data_d    = data_q;
      done_d    = 1'b0;

      case (state_q)
         c_st_idle: begin
            if (pending) begin
               rs_d    = bus.io_lcd_i[8];
               data_d  = bus.io_lcd_i[7:0];
               tgl_d   = bus.io_lcd_i[30];
               cnt_d   = c_ld_setup;
               state_d = c_st_setup;
            end
         end
         c_st_setup: begin
            if (cnt_last) begin
               cnt_d   = c_ld_pulse;
               state_d = c_st_pulse;
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         c_st_pulse: begin
            if (cnt_last) begin
               cnt_d   = c_ld_hold;
               state_d = c_st_hold;
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         c_st_hold: begin
            if (cnt_last) begin
               cnt_d   = long_cmd ? c_ld_long : c_ld_exec;
               state_d = c_st_wait;
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         c_st_wait: begin
            if (cnt_last) begin
               cnt_d     = 17'd0;
               ack_tgl_d = tgl_q;
               done_d    = 1'b1;
               state_d   = c_st_idle;
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         default: begin
            cnt_d   = 17'd0;
            state_d = c_st_idle;
         end
      endcase
   end

   // Enable comes straight from a flop so the strobe cannot glitch.
   assign en_d = (state_d == c_st_pulse);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= c_st_idle;
         cnt_q     <= 17'd0;
         ack_tgl_q <= 1'b0;
         tgl_q     <= 1'b0;
         rs_q      <= 1'b0;
         data_q    <= 8'd0;
         en_q      <= 1'b0;
         done_q    <= 1'b0;
         on_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ack_tgl_q <= ack_tgl_d;
         tgl_q     <= tgl_d;
         rs_q      <= rs_d;
         data_q    <= data_d;
         en_q      <= en_d;
         done_q    <= done_d;
         on_q      <= bus.io_lcd_i[31];
      end
   end

   assign bus.lcd_data_o = data_q;
   assign bus.lcd_rs_o   = rs_q;
   assign bus.lcd_rw_o   = 1'b0;
   assign bus.lcd_en_o   = en_q;
   assign bus.lcd_on_o   = on_q;
   assign bus.lcd_busy_o = (state_q != c_st_idle);
   assign bus.lcd_done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_ctrl
// Purpose  : Self-checking bench for lcd_ctrl: table of write transactions
//            plus hand-written back-to-back, cancel and reset-abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_ctrl;

   localparam int unsigned P_SETUP = 2;
   localparam int unsigned P_PULSE = 4;
   localparam int unsigned P_HOLD  = 2;
   localparam int unsigned P_EXEC  = 10;
   localparam int unsigned P_LONG  = 40;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   lcd_ctrl_if bus ();

   lcd_ctrl #(
      .T_SETUP     (P_SETUP),
      .T_PULSE     (P_PULSE),
      .T_HOLD      (P_HOLD),
      .T_EXEC      (P_EXEC),
      .T_EXEC_LONG (P_LONG)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [8:0] cmd;       // {rs, byte}
      int         exp_busy;  // expected busy length in cycles
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Flip the request toggle and present a new {rs, byte}.
   task automatic request(input logic [8:0] cmd);
      bus.io_lcd_i[30]  = ~bus.io_lcd_i[30];
      bus.io_lcd_i[8:0] = cmd;
   endtask

   // Watch one transaction from the cycle after the request to a few idle
   // cycles past its end; scrambles the low bits of the word while busy.
   task automatic measure(input logic [8:0] cmd,
                          output int busy_n, output int en_n, output int en_first,
                          output int done_n, output int done_idx,
                          output int hold_bad, output int timeout);
      int idle_after;
      bit started;
      busy_n = 0; en_n = 0; en_first = -1; done_n = 0; done_idx = -1;
      hold_bad = 0; timeout = 1; idle_after = 0; started = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.lcd_busy_o) begin
            started = 1'b1;
            if (bus.lcd_en_o) begin
               if (en_first < 0) en_first = busy_n;
               en_n++;
            end
            busy_n++;
            if (bus.lcd_data_o !== cmd[7:0] || bus.lcd_rs_o !== cmd[8]) hold_bad++;
            bus.io_lcd_i[8:0] = 9'($urandom);
         end else begin
            if (bus.lcd_en_o) en_n++;
            if (started) idle_after++;
         end
         if (bus.lcd_done_o) begin
            done_n++;
            if (done_idx < 0) done_idx = idle_after;
         end
         if (bus.lcd_rw_o !== 1'b0) hold_bad++;
         if (started && idle_after >= 4) begin
            timeout = 0;
            break;
         end
      end
   endtask

   // Advance to the negedge where done is seen; returns 1 on timeout.
   task automatic wait_done(output int timeout);
      timeout = 1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.lcd_done_o) begin
            timeout = 0;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_n, en_n, en_first, done_n, done_idx, hold_bad, tmo, cnt_b, cnt_d;

      vecs[0] = '{9'h141, 18};
      vecs[1] = '{9'h001, 48};
      vecs[2] = '{9'h038, 18};
      vecs[3] = '{9'h104, 18};
      vecs[4] = '{9'h002, 48};
      vecs[5] = '{9'h003, 48};
      vecs[6] = '{9'h000, 18};
      vecs[7] = '{9'h004, 18};
      vecs[8] = '{9'h101, 18};
      vecs[9] = '{9'h0FF, 18};

      // ---- reset state and power bit ----
      bus.io_lcd_i = 32'h0000_0000;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_en",   int'(bus.lcd_en_o),   0);
      chk("rst_busy", int'(bus.lcd_busy_o), 0);
      chk("rst_done", int'(bus.lcd_done_o), 0);
      chk("rst_on",   int'(bus.lcd_on_o),   0);
      chk("rst_rs",   int'(bus.lcd_rs_o),   0);
      chk("rst_data", int'(bus.lcd_data_o), 0);
      chk("rst_rw",   int'(bus.lcd_rw_o),   0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", int'(bus.lcd_busy_o), 0);
      chk("post_rst_on",   int'(bus.lcd_on_o),   0);
      bus.io_lcd_i = 32'h8000_0000;
      @(negedge clk);
      chk("on_after_1",  int'(bus.lcd_on_o),   1);
      chk("on_busy_idle", int'(bus.lcd_busy_o), 0);

      // ---- table of single transactions ----
      foreach (vecs[i]) begin
         request(vecs[i].cmd);
         measure(vecs[i].cmd, busy_n, en_n, en_first, done_n, done_idx, hold_bad, tmo);
         chk($sformatf("v%0d_timeout", i),  tmo, 0);
         chk($sformatf("v%0d_busy_len", i), busy_n, vecs[i].exp_busy);
         chk($sformatf("v%0d_en_len", i),   en_n, int'(P_PULSE));
         chk($sformatf("v%0d_en_first", i), en_first, int'(P_SETUP));
         chk($sformatf("v%0d_done_cnt", i), done_n, 1);
         chk($sformatf("v%0d_done_pos", i), done_idx, 1);
         chk($sformatf("v%0d_hold_bad", i), hold_bad, 0);
         chk($sformatf("v%0d_data_kept", i), int'(bus.lcd_data_o), int'(vecs[i].cmd[7:0]));
         chk($sformatf("v%0d_rs_kept", i),   int'(bus.lcd_rs_o),   int'(vecs[i].cmd[8]));
      end

      // ---- single flip during busy: back-to-back accept ----
      request(9'h141);
      repeat (3) @(negedge clk);
      chk("b2b_first_busy", int'(bus.lcd_busy_o), 1);
      request(9'h038);
      wait_done(tmo);
      chk("b2b_done1_timeout", tmo, 0);
      chk("b2b_done_busy0", int'(bus.lcd_busy_o), 0);
      chk("b2b_first_data", int'(bus.lcd_data_o), 8'h41);
      bus.io_lcd_i[8:0] = 9'h030;
      @(negedge clk);
      chk("b2b_second_busy", int'(bus.lcd_busy_o), 1);
      chk("b2b_second_data", int'(bus.lcd_data_o), 8'h30);
      chk("b2b_second_rs",   int'(bus.lcd_rs_o),   0);
      wait_done(tmo);
      chk("b2b_done2_timeout", tmo, 0);

      // ---- double flip during busy cancels ----
      @(negedge clk);
      request(9'h038);
      repeat (2) @(negedge clk);
      bus.io_lcd_i[30] = ~bus.io_lcd_i[30];
      repeat (3) @(negedge clk);
      bus.io_lcd_i[30] = ~bus.io_lcd_i[30];
      wait_done(tmo);
      chk("dbl_done_timeout", tmo, 0);
      cnt_b = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (bus.lcd_busy_o) cnt_b++;
      end
      chk("dbl_no_second", cnt_b, 0);

      // ---- reset during PULSE ----
      request(9'h141);
      tmo = 1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (bus.lcd_en_o) begin
            tmo = 0;
            break;
         end
      end
      chk("abort_reach_pulse", tmo, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_en",   int'(bus.lcd_en_o),   0);
      chk("abort_busy", int'(bus.lcd_busy_o), 0);
      chk("abort_done", int'(bus.lcd_done_o), 0);
      bus.io_lcd_i = 32'h8000_0000;
      @(negedge clk);
      rst_n = 1'b1;
      cnt_b = 0;
      cnt_d = 0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (bus.lcd_busy_o) cnt_b++;
         if (bus.lcd_done_o) cnt_d++;
      end
      chk("abort_stay_idle", cnt_b, 0);
      chk("abort_no_done",   cnt_d, 0);
      chk("abort_on_back",   int'(bus.lcd_on_o), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
